// File: rtl/quad_pwm_sequencer.sv
// rtl/quad_pwm_sequencer.sv - wishbone-programmed quad PWM sequencer with boundary-synchronous shadow commits
// Optional feature macro: SOFT_START_EN (adds RAMP_STEP register and ramped duty commits)
module quad_pwm_sequencer #(
  parameter int unsigned W              = 16,
  parameter logic [31:0] BASE_ADDR      = 32'h3000_0000,
  parameter logic [W-1:0] DEFAULT_PERIOD = W'(1000)
) (
  input  logic           wb_clk_i,
  input  logic           wb_rst_ni,
  input  logic           wbs_stb_i,
  input  logic           wbs_cyc_i,
  input  logic           wbs_we_i,
  input  logic [3:0]     wbs_sel_i,
  input  logic [31:0]    wbs_dat_i,
  input  logic [31:0]    wbs_adr_i,
  output logic           wbs_ack_o,
  output logic [31:0]    wbs_dat_o,
  output logic [4*W-1:0] duty_o,
  output logic [W-1:0]   period_o,
  output logic [3:0]     ch_en_o,
  output logic           sync_o,
  output logic           irq_o
);

  // Bus request captured at the hit, serviced on the following (ack) cycle
  logic        ack_q, ack_d;
  logic [2:0]  radr_q, radr_d;
  logic        rwe_q, rwe_d;
  logic [3:0]  rsel_q, rsel_d;
  logic [31:0] rdat_q, rdat_d;

  // Programming model: shadow registers and the active copies driven to the channels
  logic [5:0]          ctrl_q, ctrl_d;
  logic [W-1:0]        per_sh_q, per_sh_d;
  logic [W-1:0]        per_act_q, per_act_d;
  logic [3:0][W-1:0]   duty_sh_q, duty_sh_d;
  logic [3:0][W-1:0]   duty_act_q, duty_act_d;
  logic [W-1:0]        cnt_q, cnt_d;
  logic                pend_q, pend_d;
  logic                irq_q, irq_d;
  logic                sync_q, sync_d;
`ifdef SOFT_START_EN
  logic [W-1:0]        ramp_q, ramp_d;
`endif

  logic        hit, accept, wr, wr_shadow, irq_clr;
  logic        run, boundary, commit_done;
  logic [31:0] rdata, wmerged;
  logic        unused_bits;

  assign hit    = wbs_stb_i & wbs_cyc_i & (wbs_adr_i[31:5] == BASE_ADDR[31:5]);
  assign accept = hit & ~ack_q;
  assign wr     = ack_q & rwe_q;
  assign run    = ctrl_q[4];
  assign boundary = run & (cnt_q == per_act_q);
  assign unused_bits = ^{wbs_adr_i[1:0], wmerged, rdat_q};

`ifdef SOFT_START_EN
  // Move cur toward tgt by at most step; a zero step jumps straight to the target
  function automatic logic [W-1:0] ramp_toward(input logic [W-1:0] cur, input logic [W-1:0] tgt,
                                               input logic [W-1:0] step);
    logic [W-1:0] r;
    r = tgt;
    if (step != '0) begin
      if (tgt > cur) begin
        if ((tgt - cur) > step) r = cur + step;
      end else if ((cur - tgt) > step) begin
        r = cur - step;
      end
    end
    return r;
  endfunction
`endif

  // Bus handshake: ack one cycle after an accepted hit, never back-to-back
  always_comb begin
    ack_d  = accept;
    radr_d = radr_q;
    rwe_d  = rwe_q;
    rsel_d = rsel_q;
    rdat_d = rdat_q;
    if (accept) begin
      radr_d = wbs_adr_i[4:2];
      rwe_d  = wbs_we_i;
      rsel_d = wbs_sel_i;
      rdat_d = wbs_dat_i;
    end
  end

  // Register read mux, also the base value for byte-masked writes
  always_comb begin
    rdata = '0;
    case (radr_q)
      3'd0: rdata = {26'd0, ctrl_q};
      3'd1: rdata = 32'(per_sh_q);
      3'd2: rdata = 32'(duty_sh_q[0]);
      3'd3: rdata = 32'(duty_sh_q[1]);
      3'd4: rdata = 32'(duty_sh_q[2]);
      3'd5: rdata = 32'(duty_sh_q[3]);
      3'd6: rdata = {30'd0, irq_q, pend_q};
`ifdef SOFT_START_EN
      3'd7: rdata = 32'(ramp_q);
`endif
      default: rdata = '0;
    endcase
  end

  // Byte-select merge of the write data over the current register value
  always_comb begin
    wmerged = rdata;
    for (int b = 0; b < 4; b++) begin
      if (rsel_q[b]) wmerged[8*b +: 8] = rdat_q[8*b +: 8];
    end
  end

  // Register writes on the ack cycle; shadow writes flag a pending commit
  always_comb begin
    ctrl_d    = ctrl_q;
    per_sh_d  = per_sh_q;
    duty_sh_d = duty_sh_q;
    wr_shadow = 1'b0;
    irq_clr   = 1'b0;
`ifdef SOFT_START_EN
    ramp_d    = ramp_q;
`endif
    if (wr) begin
      case (radr_q)
        3'd0: ctrl_d = wmerged[5:0];
        3'd1: begin per_sh_d     = wmerged[W-1:0]; wr_shadow = 1'b1; end
        3'd2: begin duty_sh_d[0] = wmerged[W-1:0]; wr_shadow = 1'b1; end
        3'd3: begin duty_sh_d[1] = wmerged[W-1:0]; wr_shadow = 1'b1; end
        3'd4: begin duty_sh_d[2] = wmerged[W-1:0]; wr_shadow = 1'b1; end
        3'd5: begin duty_sh_d[3] = wmerged[W-1:0]; wr_shadow = 1'b1; end
        3'd6: irq_clr = rsel_q[0] & rdat_q[1];
`ifdef SOFT_START_EN
        3'd7: ramp_d = wmerged[W-1:0];
`endif
        default: ;
      endcase
    end
  end

  // Period counter, boundary commit of shadows, pending/IRQ bookkeeping and sync pulse
  always_comb begin
    cnt_d       = cnt_q;
    per_act_d   = per_act_q;
    duty_act_d  = duty_act_q;
    pend_d      = pend_q;
    commit_done = 1'b0;
    if (!run) begin
      // Stopped: actives simply track the shadows and nothing is pending
      cnt_d      = '0;
      per_act_d  = per_sh_q;
      duty_act_d = duty_sh_q;
      pend_d     = 1'b0;
    end else begin
      cnt_d = boundary ? '0 : cnt_q + W'(1);
      if (boundary && pend_q) begin
        per_act_d = per_sh_q;
`ifdef SOFT_START_EN
        for (int i = 0; i < 4; i++) begin
          duty_act_d[i] = ramp_toward(duty_act_q[i], duty_sh_q[i], ramp_q);
        end
        commit_done = (duty_act_d == duty_sh_q);
`else
        duty_act_d  = duty_sh_q;
        commit_done = 1'b1;
`endif
      end
      // A write landing on the boundary keeps pending for the next period
      pend_d = wr_shadow | (pend_q & ~commit_done);
    end
    irq_d  = (commit_done & ~wr_shadow) | (irq_q & ~irq_clr);
    sync_d = ctrl_d[4] & (~run | boundary);
  end

  // State registers with asynchronous active-low reset
  always_ff @(posedge wb_clk_i or negedge wb_rst_ni) begin
    if (!wb_rst_ni) begin
      ack_q      <= 1'b0;
      radr_q     <= '0;
      rwe_q      <= 1'b0;
      rsel_q     <= '0;
      rdat_q     <= '0;
      ctrl_q     <= '0;
      per_sh_q   <= DEFAULT_PERIOD;
      per_act_q  <= DEFAULT_PERIOD;
      duty_sh_q  <= '0;
      duty_act_q <= '0;
      cnt_q      <= '0;
      pend_q     <= 1'b0;
      irq_q      <= 1'b0;
      sync_q     <= 1'b0;
`ifdef SOFT_START_EN
      ramp_q     <= '0;
`endif
    end else begin
      ack_q      <= ack_d;
      radr_q     <= radr_d;
      rwe_q      <= rwe_d;
      rsel_q     <= rsel_d;
      rdat_q     <= rdat_d;
      ctrl_q     <= ctrl_d;
      per_sh_q   <= per_sh_d;
      per_act_q  <= per_act_d;
      duty_sh_q  <= duty_sh_d;
      duty_act_q <= duty_act_d;
      cnt_q      <= cnt_d;
      pend_q     <= pend_d;
      irq_q      <= irq_d;
      sync_q     <= sync_d;
`ifdef SOFT_START_EN
      ramp_q     <= ramp_d;
`endif
    end
  end

  assign wbs_ack_o = ack_q;
  assign wbs_dat_o = ack_q ? rdata : 32'd0;
  assign duty_o    = duty_act_q;
  assign period_o  = per_act_q;
  assign ch_en_o   = ctrl_q[3:0] & {4{ctrl_q[4]}};
  assign sync_o    = sync_q;
  assign irq_o     = irq_q & ctrl_q[5];

endmodule

// File: tb/tb_quad_pwm_sequencer.sv
// tb/tb_quad_pwm_sequencer.sv - directed self-checking bench for quad_pwm_sequencer
module tb_quad_pwm_sequencer;

  localparam logic [31:0] BASE = 32'h3000_0000;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        stb, cyc, we;
  logic [3:0]  sel;
  logic [31:0] dat_i, adr;
  logic        ack;
  logic [31:0] dat_o;
  logic [63:0] duty;
  logic [15:0] period;
  logic [3:0]  ch_en;
  logic        sync, irq;

  int n_checks = 0;
  int n_fail   = 0;

  quad_pwm_sequencer dut (
    .wb_clk_i (clk),
    .wb_rst_ni(rst_n),
    .wbs_stb_i(stb),
    .wbs_cyc_i(cyc),
    .wbs_we_i (we),
    .wbs_sel_i(sel),
    .wbs_dat_i(dat_i),
    .wbs_adr_i(adr),
    .wbs_ack_o(ack),
    .wbs_dat_o(dat_o),
    .duty_o   (duty),
    .period_o (period),
    .ch_en_o  (ch_en),
    .sync_o   (sync),
    .irq_o    (irq)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic wb_xfer(input logic [31:0] a, input logic w, input logic [31:0] d,
                         output logic [31:0] rd);
    logic got;
    got = 1'b0;
    rd  = '0;
    @(negedge clk);
    stb = 1'b1; cyc = 1'b1; we = w; adr = a; dat_i = d; sel = 4'hF;
    for (int i = 0; i < 4; i++) begin
      @(posedge clk); #1;
      if (ack) begin got = 1'b1; rd = dat_o; break; end
    end
    stb = 1'b0; cyc = 1'b0; we = 1'b0;
    check("bus_ack", got, 1);
  endtask

  task automatic wb_write(input logic [31:0] a, input logic [31:0] d);
    logic [31:0] unused_rd;
    wb_xfer(a, 1'b1, d, unused_rd);
  endtask

  task automatic wb_read(input logic [31:0] a, output logic [31:0] rd);
    wb_xfer(a, 1'b0, 32'd0, rd);
  endtask

  task automatic wait_sync(input string tag);
    logic got;
    got = 1'b0;
    for (int i = 0; i < 40; i++) begin
      @(posedge clk); #1;
      if (sync) begin got = 1'b1; break; end
    end
    check(tag, got, 1);
  endtask

  initial begin
    logic [31:0] rd;
    logic [3:0]  pat;
    logic        seen;
    int          n;
    int          exp_ramp[4];
    exp_ramp = '{3, 6, 9, 10};

    rst_n = 1'b0; stb = 1'b0; cyc = 1'b0; we = 1'b0; sel = 4'h0; dat_i = '0; adr = '0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_period", period, 1000);
    check("rst_duty", duty, 0);
    check("rst_ch_en", ch_en, 0);
    check("rst_irq", irq, 0);
    check("rst_ack", ack, 0);
    @(negedge clk); rst_n = 1'b1;
    @(posedge clk); #1;
    check("post_rst_period", period, 1000);
    check("post_rst_sync", sync, 0);

    // Stopped: shadows are transparent, nothing becomes pending
    wb_write(BASE + 32'h04, 32'd9);
    wb_write(BASE + 32'h08, 32'd4);
    wb_read(BASE + 32'h18, rd);
    check("status_idle", rd, 0);
    wb_write(BASE + 32'h00, 32'h3F);
    @(posedge clk); #1;
    check("run_start_sync", sync, 1);
    check("ch_en_all", ch_en, 4'hF);
    check("period_9", period, 9);
    check("duty0_4", duty[15:0], 4);
    n = 0;
    for (int i = 1; i <= 20; i++) begin
      @(posedge clk); #1;
      if (sync) begin n = i; break; end
    end
    check("sync_spacing", n, 10);

    // Mid-period DUTY1 write waits for the boundary
    wb_write(BASE + 32'h0C, 32'd7);
    @(posedge clk); #1;
    check("duty1_held", duty[31:16], 0);
    wb_read(BASE + 32'h18, rd);
    check("status_pending", rd, 1);
    wait_sync("sync_commit1");
    check("duty1_commit", duty[31:16], 7);
    wb_read(BASE + 32'h18, rd);
    check("status_after", rd, 2);
    check("irq_set", irq, 1);
    wb_write(BASE + 32'h18, 32'd2);
    @(posedge clk); #1;
    check("irq_w1c", irq, 0);

    // DUTY3 mid-period, then DUTY2 acked exactly on the boundary cycle
    wait_sync("sync_align");
    wb_write(BASE + 32'h14, 32'd2);
    repeat (7) @(negedge clk);
    wb_write(BASE + 32'h10, 32'd5);
    @(posedge clk); #1;
    check("bnd_sync", sync, 1);
    check("bnd_duty3", duty[63:48], 2);
    check("bnd_duty2_held", duty[47:32], 0);
    check("bnd_no_irq", irq, 0);
    wait_sync("sync_next");
    check("bnd_duty2_late", duty[47:32], 5);
    check("bnd_irq", irq, 1);

    // Duty above period passes through unchanged
    wb_write(BASE + 32'h08, 32'd50);
    wait_sync("sync_duty50");
    check("duty0_over", duty[15:0], 50);

    // Period 0 gives a boundary every cycle
    wb_write(BASE + 32'h04, 32'd0);
    wait_sync("sync_per0");
    check("period_0", period, 0);
    n = 0;
    for (int i = 0; i < 3; i++) begin
      @(posedge clk); #1;
      if (sync) n++;
    end
    check("per0_every_cycle", n, 3);

    // Strobe held high: ack alternates
    @(negedge clk);
    stb = 1'b1; cyc = 1'b1; we = 1'b0; adr = BASE; sel = 4'hF;
    #1;
    pat[3] = ack;
    @(posedge clk); #1; pat[2] = ack;
    check("b2b_rdata", dat_o, 32'h3F);
    @(posedge clk); #1; pat[1] = ack;
    check("b2b_dat_idle", dat_o, 0);
    @(posedge clk); #1; pat[0] = ack;
    stb = 1'b0; cyc = 1'b0;
    check("b2b_ack_pattern", pat, 4'b0101);

    // Address outside the window: no ack, no write
    @(negedge clk);
    stb = 1'b1; cyc = 1'b1; we = 1'b1; adr = BASE + 32'h40; dat_i = 32'h0; sel = 4'hF;
    seen = 1'b0;
    for (int i = 0; i < 4; i++) begin
      @(posedge clk); #1;
      if (ack) seen = 1'b1;
    end
    stb = 1'b0; cyc = 1'b0; we = 1'b0;
    check("miss_no_ack", seen, 0);
    check("miss_no_write", ch_en, 4'hF);

    // Asynchronous reset between clock edges
    @(posedge clk); #3;
    rst_n = 1'b0;
    #1;
    check("arst_period", period, 1000);
    check("arst_duty", duty, 0);
    check("arst_ch_en", ch_en, 0);
    check("arst_irq", irq, 0);
    check("arst_sync", sync, 0);
    check("arst_ack", ack, 0);
    @(negedge clk); rst_n = 1'b1;

`ifdef SOFT_START_EN
    wb_write(BASE + 32'h04, 32'd9);
    wb_write(BASE + 32'h1C, 32'd3);
    wb_read(BASE + 32'h1C, rd);
    check("ramp_readback", rd, 3);
    wb_write(BASE + 32'h00, 32'h3F);
    wait_sync("ramp_start");
    wb_write(BASE + 32'h08, 32'd10);
    for (int i = 0; i < 4; i++) begin
      wait_sync("ramp_sync");
      check("ramp_duty0", duty[15:0], exp_ramp[i]);
      check("ramp_irq", irq, (i == 3));
    end
`else
    wb_write(BASE + 32'h1C, 32'd5);
    wb_read(BASE + 32'h1C, rd);
    check("ramp_absent", rd, 0);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
